// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered ALU for the basic-computer datapath.
//
// Executes the AC/DR/E/INPR operations under a start/done handshake.
// Single-cycle operations register their result at the edge that samples
// `start`; the optional shift-add multiply runs for WIDTH cycles in a MUL
// state before registering its result.
//
// Optional feature macro: ALU_MUL_EN
//   defined   -> MUL state, step counter, product register and code 0100 exist.
//   undefined -> none of that logic exists; busy is tied low and code 0100
//                behaves as an unknown code.
//
// Ports:
//   clk          in   1           single clock, rising edge
//   rst          in   1           synchronous, active-high reset
//   start        in   1           request, sampled only in IDLE
//   alu_code     in   4           operation, sampled with start
//   ac_outdata   in   WIDTH       AC operand
//   dr_outdata   in   WIDTH       DR operand
//   e_outdata    in   1           current E flag
//   inpr_outdata in   INPR_WIDTH  input character
//   alu_outdata  out  WIDTH       registered result, held between operations
//   e_indata     out  1           registered new E value
//   ff_en        out  1           one-cycle E-load strobe, coincident with done
//   done         out  1           one-cycle completion pulse
//   busy         out  1           high while a multiply is in progress
//
// Handshake: a request is accepted when start=1 at a rising edge while the
// unit is idle (busy=0 during the preceding cycle). Every accepted request
// produces exactly one done pulse; requests made while busy are dropped.
// start during the done cycle is accepted. rst wins over start.

module alu_seq_unit #(
  parameter int WIDTH      = 16,
  parameter int INPR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            alu_code,
  input  logic [WIDTH-1:0]      ac_outdata,
  input  logic [WIDTH-1:0]      dr_outdata,
  input  logic                  e_outdata,
  input  logic [INPR_WIDTH-1:0] inpr_outdata,
  output logic [WIDTH-1:0]      alu_outdata,
  output logic                  e_indata,
  output logic                  ff_en,
  output logic                  done,
  output logic                  busy
);

  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_LDA = 4'b0011;
  localparam logic [3:0] OP_CMA = 4'b1001;
  localparam logic [3:0] OP_CME = 4'b1010;
  localparam logic [3:0] OP_CIR = 4'b1011;
  localparam logic [3:0] OP_CIL = 4'b1100;
  localparam logic [3:0] OP_INP = 4'b1101;

  // Single-cycle result. Unknown codes (and 0100 when the multiplier is
  // absent) fall to the default and leave both outputs unchanged.
  logic [WIDTH-1:0] sc_out;
  logic             sc_e;
  logic             sc_ff;

  always_comb begin
    sc_out = alu_outdata;
    sc_e   = e_indata;
    sc_ff  = 1'b0;
    case (alu_code)
      OP_AND: sc_out = ac_outdata & dr_outdata;
      OP_ADD: begin
        {sc_e, sc_out} = {1'b0, ac_outdata} + {1'b0, dr_outdata};
        sc_ff = 1'b1;
      end
      OP_LDA: sc_out = dr_outdata;
      OP_CMA: sc_out = ~ac_outdata;
      OP_CME: begin
        sc_e  = ~e_outdata;
        sc_ff = 1'b1;
      end
      // Rotates take E from the input port, never from e_indata, so a
      // rotate issued right after an E-changing op cannot see a stale E.
      OP_CIR: begin
        sc_out = {e_outdata, ac_outdata[WIDTH-1:1]};
        sc_e   = ac_outdata[0];
        sc_ff  = 1'b1;
      end
      OP_CIL: begin
        sc_out = {ac_outdata[WIDTH-2:0], e_outdata};
        sc_e   = ac_outdata[WIDTH-1];
        sc_ff  = 1'b1;
      end
      OP_INP: sc_out = {ac_outdata[WIDTH-1:INPR_WIDTH], inpr_outdata};
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam int         CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  // `state` is the observable FSM state for checkers.
  state_t             state;
  logic [CW-1:0]      step;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] prod_next;

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set.
  assign prod_next = product + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      step        <= '0;
      mcand       <= '0;
      mplier      <= '0;
      product     <= '0;
      alu_outdata <= '0;
      e_indata    <= 1'b0;
      ff_en       <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      done  <= 1'b0;
      ff_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (alu_code == OP_MUL) begin
              mcand   <= {{WIDTH{1'b0}}, ac_outdata};
              mplier  <= dr_outdata;
              product <= '0;
              step    <= '0;
              busy    <= 1'b1;
              state   <= S_MUL;
            end else begin
              alu_outdata <= sc_out;
              e_indata    <= sc_e;
              ff_en       <= sc_ff;
              done        <= 1'b1;
            end
          end
        end
        S_MUL: begin
          product <= prod_next;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          step    <= step + 1'b1;
          // The final step's sum goes straight to the outputs so busy
          // falls at the same edge done rises.
          if (step == LAST_STEP) begin
            alu_outdata <= prod_next[WIDTH-1:0];
            e_indata    <= |prod_next[2*WIDTH-1:WIDTH];
            ff_en       <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_outdata <= '0;
      e_indata    <= 1'b0;
      ff_en       <= 1'b0;
      done        <= 1'b0;
    end else begin
      done  <= start;
      ff_en <= start & sc_ff;
      if (start) begin
        alu_outdata <= sc_out;
        e_indata    <= sc_e;
      end
    end
  end

  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed self-checking bench for alu_seq_unit
// (WIDTH=16, INPR_WIDTH=8). Covers the multiplier sections when ALU_MUL_EN
// is defined, and code 0100 as an unknown code otherwise.

module tb_alu_seq_unit;

  localparam int W  = 16;
  localparam int IW = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    alu_code;
  logic [W-1:0]  ac, dr;
  logic          e_in;
  logic [IW-1:0] inpr;
  logic [W-1:0]  alu_outdata;
  logic          e_indata, ff_en, done, busy;

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(W), .INPR_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_code(alu_code),
    .ac_outdata(ac), .dr_outdata(dr), .e_outdata(e_in), .inpr_outdata(inpr),
    .alu_outdata(alu_outdata), .e_indata(e_indata), .ff_en(ff_en),
    .done(done), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Architectural view: an accepted request completes after 1 cycle, or
  // after W cycles for a multiply; nothing is accepted while one is pending.
  logic [W-1:0]  exp_out;
  logic          exp_e, exp_done, exp_ff, exp_busy;
  logic [W:0]    exp_q[$];
  int            mul_left;
  logic [W-1:0]  mul_out;
  logic          mul_e;
  bit            model_live = 0;

  task automatic ref_op(input logic [3:0] code, input logic [W-1:0] a, d,
                        input logic e, input logic [IW-1:0] in,
                        input logic [W-1:0] po, input logic pe,
                        output logic [W-1:0] o, output logic oe, output logic off);
    int sum;
    o = po; oe = pe; off = 1'b0;
    case (code)
      4'b0001: o = a & d;
      4'b0010: begin
        sum = int'(a) + int'(d);
        o = sum[W-1:0]; oe = (sum > 65535); off = 1'b1;
      end
      4'b0011: o = d;
      4'b1001: o = 16'hFFFF - a;
      4'b1010: begin oe = !e; off = 1'b1; end
      4'b1011: begin o = (a >> 1) + (e ? 16'h8000 : 16'h0000); oe = a[0]; off = 1'b1; end
      4'b1100: begin o = (a << 1) + {15'd0, e}; oe = a[W-1]; off = 1'b1; end
      4'b1101: o = (a & 16'hFF00) | {8'h00, in};
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    logic [W-1:0] o;
    logic oe, off;
    logic [31:0] prod;
    model_live = 1;
    exp_done = 1'b0;
    exp_ff   = 1'b0;
    if (rst) begin
      exp_out = '0; exp_e = 1'b0; exp_busy = 1'b0; mul_left = 0;
      exp_q.delete();
    end else if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) begin
        exp_out = mul_out; exp_e = mul_e; exp_done = 1'b1; exp_ff = 1'b1;
        exp_busy = 1'b0;
        exp_q.push_back({exp_e, exp_out});
      end
    end else if (start) begin
`ifdef ALU_MUL_EN
      if (alu_code == 4'b0100) begin
        prod = 32'(ac) * 32'(dr);
        mul_out = prod[15:0];
        mul_e = (prod[31:16] != 16'h0000);
        mul_left = W;
        exp_busy = 1'b1;
      end else
`endif
      begin
        ref_op(alu_code, ac, dr, e_in, inpr, exp_out, exp_e, o, oe, off);
        exp_out = o; exp_e = oe; exp_done = 1'b1; exp_ff = off;
        exp_q.push_back({exp_e, exp_out});
      end
    end
  end

  // ---------------- compare process / scoreboard ----------------
  always @(negedge clk) begin
    logic [W:0] r;
    if (model_live) begin
      check("done", done, exp_done);
      check("ff_en", ff_en, exp_ff);
      check("busy", busy, exp_busy);
      check("alu_outdata", alu_outdata, exp_out);
      check("e_indata", e_indata, exp_e);
      if (done) begin
        if (exp_q.size() == 0) check("sb_unexpected_done", 1, 0);
        else begin
          r = exp_q.pop_front();
          check("sb_result", {e_indata, alu_outdata}, r);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the sampling edge,
  // where single-cycle results are visible.
  task automatic op(input logic [3:0] code, input logic [W-1:0] a, d,
                    input logic e, input logic [IW-1:0] in);
    alu_code = code; ac = a; dr = d; e_in = e; inpr = in; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

`ifdef ALU_MUL_EN
  task automatic mul_run(input logic [W-1:0] a, d, input bit poke,
                         input logic [W-1:0] eo, input logic ee);
    int nbusy = 0;
    bit seen = 0;
    op(4'b0100, a, d, 1'b0, 8'h00);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (busy) nbusy++;
        if (i == 2) begin ac = 16'hFFFF; dr = 16'hFFFF; end
        if (poke && i == 3) begin alu_code = 4'b0010; start = 1'b1; end
        else start = 1'b0;
        @(negedge clk);
      end
    end
    start = 1'b0;
    check("mul_done_seen", seen, 1);
    check("mul_busy_cycles", nbusy, 16);
    check("mul_out", alu_outdata, eo);
    check("mul_e", e_indata, ee);
    check("mul_ff_en", ff_en, 1);
  endtask
`endif

  logic [3:0]   bb_code[6] = '{4'b0001, 4'b0011, 4'b1001, 4'b1010, 4'b0010, 4'b1100};
  logic [W-1:0] bb_a[6]    = '{16'hF0F0, 16'h1234, 16'h00FF, 16'h7777, 16'h8001, 16'hC003};
  logic [W-1:0] bb_d[6]    = '{16'h0FF0, 16'hBEEF, 16'h0000, 16'h1111, 16'h7FFF, 16'h0001};

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; alu_code = 4'h0; ac = '0; dr = '0; e_in = 1'b0; inpr = '0;
    repeat (2) @(negedge clk);
    check("rst_out", alu_outdata, 16'h0000);
    check("rst_e", e_indata, 0);
    check("rst_done", done, 0);
    check("rst_ff", ff_en, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    op(4'b0010, 16'hFFFF, 16'h0001, 1'b0, 8'h00);
    check("add_out", alu_outdata, 16'h0000);
    check("add_e", e_indata, 1);
    check("add_ff", ff_en, 1);
    check("add_done", done, 1);

    op(4'b1011, 16'h0001, 16'h0000, 1'b1, 8'h00);
    check("cir_out", alu_outdata, 16'h8000);
    check("cir_e", e_indata, 1);
    op(4'b1100, 16'h8000, 16'h0000, 1'b0, 8'h00);
    check("cil_out", alu_outdata, 16'h0000);
    check("cil_e", e_indata, 1);

    op(4'b1101, 16'hABCD, 16'h0000, 1'b0, 8'h5A);
    check("inp_out", alu_outdata, 16'hAB5A);
    check("inp_ff", ff_en, 0);
    check("inp_e_held", e_indata, 1);

    op(4'b1111, 16'h1234, 16'h5678, 1'b0, 8'h00);
    check("unk_done", done, 1);
    check("unk_out", alu_outdata, 16'hAB5A);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    op(4'b0001, 16'hF0F0, 16'h3C3C, 1'b0, 8'h00);
    check("and_out", alu_outdata, 16'h3030);
    op(4'b1001, 16'h00FF, 16'h0000, 1'b0, 8'h00);
    check("cma_out", alu_outdata, 16'hFF00);
    op(4'b1010, 16'h0000, 16'h0000, 1'b1, 8'h00);
    check("cme_e", e_indata, 0);

    // Back-to-back requests, one per cycle.
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      alu_code = bb_code[i]; ac = bb_a[i]; dr = bb_d[i]; e_in = i[0];
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);

    // Reset and start together: reset wins.
    rst = 1'b1; alu_code = 4'b0010; ac = 16'h0005; dr = 16'h0006; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_out", alu_outdata, 16'h0000);
    check("rst_start_done", done, 0);
    @(negedge clk);

`ifdef ALU_MUL_EN
    mul_run(16'h0102, 16'h0003, 1'b1, 16'h0306, 1'b0);
    @(negedge clk);
    mul_run(16'hFFFF, 16'h0002, 1'b0, 16'hFFFE, 1'b1);
    @(negedge clk);
    op(4'b0100, 16'h1234, 16'h0056, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out", alu_outdata, 16'h0000);
    check("abort_e", e_indata, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    op(4'b0010, 16'h0003, 16'h0004, 1'b0, 8'h00);
    check("post_abort_add_out", alu_outdata, 16'h0007);
    check("post_abort_add_done", done, 1);
`else
    op(4'b0010, 16'h0003, 16'h0004, 1'b0, 8'h00);
    op(4'b0100, 16'h0102, 16'h0003, 1'b1, 8'h00);
    check("mul_off_done", done, 1);
    check("mul_off_ff", ff_en, 0);
    check("mul_off_out", alu_outdata, 16'h0007);
    check("mul_off_busy", busy, 0);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
